// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block: divider FSM states, iteration count
// and the magnitude helper used by the sequential divider.
package arith_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } div_state_e;

  localparam int unsigned DIV_ITERS   = 8;
  localparam logic [7:0]  DBZ_DEFAULT = 8'hFF;

  // Two's-complement magnitude; -128 maps to 8'h80, read as unsigned 128 downstream.
  function automatic logic [7:0] mag8(input logic [7:0] x, input logic is_signed);
    return (is_signed && x[7]) ? (~x + 8'd1) : x;
  endfunction

endpackage

// File: rtl/divider_8bit_seq_if.sv
// Start/done handshake and result bus between the sequencer and the sequential divider.
interface divider_8bit_seq_if;

  logic       start;
  logic       signed_mode;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/subtracter_8bit.sv
// 8-bit subtracter; borrow = 1 means no borrow was needed (a >= b unsigned).
module subtracter_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);

  logic [8:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + 9'd1;
  assign diff   = sum[7:0];
  assign borrow = sum[8];

endmodule

// File: rtl/divider_8bit_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned operands.
// Results are published to the bus together with the done pulse.
module divider_8bit_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [7:0]  DBZ_QUOT = DBZ_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  divider_8bit_seq_if.slave bus
);

  if (WIDTH != 8) begin : gen_bad_width
    $error("divider_8bit_seq: WIDTH must be 8 to match subtracter_8bit");
  end

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  div_state_e      state_q;
  logic [7:0]      dvd_q, dvs_q;
  logic            smode_q;
  logic            q_neg_q, r_neg_q;
  logic [7:0]      q_q, r_q, d_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      res_quot_q, res_rem_q;
  logic            res_dbz_q, res_ovf_q;
  logic            busy_q, done_q;
  logic [7:0]      quot_q, rem_q;
  logic            dbz_q, ovf_q;

  logic [7:0] r_sh;
  logic       r_msb;
  logic [7:0] sub_diff;
  logic       sub_borrow;
  logic       accept;

  // The bit shifted out of R is the 9th bit of the partial remainder.
  assign r_msb  = r_q[7];
  assign r_sh   = {r_q[6:0], q_q[7]};
  assign accept = r_msb | sub_borrow;

  subtracter_8bit u_sub (
    .a      (r_sh),
    .b      (d_q),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dvd_q      <= '0;
      dvs_q      <= '0;
      smode_q    <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      res_dbz_q  <= 1'b0;
      res_ovf_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      busy_q <= (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
      done_q <= (state_q == StDone);
      case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone) begin
            quot_q <= res_quot_q;
            rem_q  <= res_rem_q;
            dbz_q  <= res_dbz_q;
            ovf_q  <= res_ovf_q;
          end
          if (bus.start) begin
            dvd_q     <= bus.dividend;
            dvs_q     <= bus.divisor;
            smode_q   <= bus.signed_mode;
            res_dbz_q <= 1'b0;
            res_ovf_q <= 1'b0;
            // A start in DONE coincides with publishing, which must win.
            if (state_q == StIdle) begin
              dbz_q <= 1'b0;
              ovf_q <= 1'b0;
            end
            state_q <= StPrep;
          end else begin
            state_q <= StIdle;
          end
        end
        StPrep: begin
          if (dvs_q == 8'd0) begin
            res_quot_q <= DBZ_QUOT;
            res_rem_q  <= dvd_q;
            res_dbz_q  <= 1'b1;
            state_q    <= StDone;
          end else begin
            q_neg_q <= smode_q & (dvd_q[7] ^ dvs_q[7]);
            r_neg_q <= smode_q & dvd_q[7];
            q_q     <= mag8(dvd_q, smode_q);
            d_q     <= mag8(dvs_q, smode_q);
            r_q     <= '0;
            cnt_q   <= CntW'(DIV_ITERS - 1);
            state_q <= StIter;
          end
        end
        StIter: begin
          r_q   <= accept ? sub_diff : r_sh;
          q_q   <= {q_q[6:0], accept};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (smode_q && (dvd_q == 8'h80) && (dvs_q == 8'hFF)) begin
            res_ovf_q  <= 1'b1;
            res_quot_q <= 8'h80;
            res_rem_q  <= 8'h00;
          end else begin
            res_quot_q <= q_neg_q ? (~q_q + 8'd1) : q_q;
            res_rem_q  <= r_neg_q ? (~r_q + 8'd1) : r_q;
          end
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Directed bench for divider_8bit_seq: hand-computed quotients, flags, latency and
// handshake corner cases (ignored start, back-to-back start, reset mid-operation).
module tb_divider_8bit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  divider_8bit_seq_if bus ();

  divider_8bit_seq #(
    .WIDTH    (8),
    .DBZ_QUOT (8'hFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic sm, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Samples 1 time unit after each rising edge; lat counts edges after the start edge.
  task automatic wait_done(input int lat0, output int lat, output int busy_cycles);
    lat = lat0;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic run(input string tag, input logic sm, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er,
                     input logic edbz, input logic eovf, input int elat);
    int lat, bc;
    launch(sm, a, b);
    check({tag, "_flags_cleared"}, {bus.div_by_zero, bus.overflow}, 2'b00);
    wait_done(0, lat, bc);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_div_by_zero"}, bus.div_by_zero, edbz);
    check({tag, "_overflow"}, bus.overflow, eovf);
    if (elat == 11) check({tag, "_busy_cycles"}, bc, 10);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_quotient_held"}, bus.quotient, eq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, done_seen;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = 8'd0;
    bus.divisor     = 8'd0;
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_quotient", bus.quotient, 8'h00);
    check("reset_remainder", bus.remainder, 8'h00);
    check("reset_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("u200_7",  1'b0, 8'd200, 8'd7,  8'h1C, 8'h04, 1'b0, 1'b0, 11);
    run("u255_1",  1'b0, 8'd255, 8'd1,  8'hFF, 8'h00, 1'b0, 1'b0, 11);
    run("u5_9",    1'b0, 8'd5,   8'd9,  8'h00, 8'h05, 1'b0, 1'b0, 11);
    run("s-7_2",   1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 11);
    run("s7_-2",   1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 11);
    run("u13_0",   1'b0, 8'd13,  8'd0,  8'hFF, 8'h0D, 1'b1, 1'b0, 2);
    run("s80_ff",  1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 11);
    run("s-128_2", 1'b1, 8'h80,  8'h02, 8'hC0, 8'h00, 1'b0, 1'b0, 11);
    run("s-7_0",   1'b1, 8'hF9,  8'h00, 8'hFF, 8'hF9, 1'b1, 1'b0, 2);

    // start pulsed mid-ITER with a divide-by-zero request must be ignored
    launch(1'b0, 8'd200, 8'd7);
    lat = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    bus.dividend = 8'd13;
    bus.divisor  = 8'd0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    wait_done(lat, lat, bc);
    check("ignore_latency", lat, 11);
    check("ignore_quotient", bus.quotient, 8'h1C);
    check("ignore_remainder", bus.remainder, 8'h04);
    check("ignore_dbz", bus.div_by_zero, 1'b0);

    // start held into the DONE cycle launches the next division with no gap
    @(negedge clk);
    bus.signed_mode = 1'b0;
    bus.dividend    = 8'd100;
    bus.divisor     = 8'd10;
    bus.start       = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    check("b2b_first_done", bus.done, 1'b1);
    check("b2b_first_quotient", bus.quotient, 8'h0A);
    check("b2b_first_remainder", bus.remainder, 8'h00);
    check("b2b_busy_in_done", bus.busy, 1'b0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_busy_no_gap", bus.busy, 1'b1);
    check("b2b_done_pulse", bus.done, 1'b0);
    wait_done(1, lat, bc);
    check("b2b_second_latency", lat, 11);
    check("b2b_second_quotient", bus.quotient, 8'h10);
    check("b2b_second_remainder", bus.remainder, 8'h02);

    // asynchronous reset mid-ITER clears every output and suppresses done
    launch(1'b0, 8'd200, 8'd7);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_quotient", bus.quotient, 8'h00);
    check("arst_remainder", bus.remainder, 8'h00);
    check("arst_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    run("post_rst_u100_7", 1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
